if_fetch_queue: RTL and testbench

// Parametrised instruction-fetch front end for the MIPS pipeline. Replaces single-entry IF buffering with

---
 rtl/if_fetch_queue.sv | 226 ++++++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch front end. Issues several instruction reads on
//            an sram-like bus and queues the returned instructions, each tagged
//            with its PC, in front of the decode stage. A redirect flushes the
//            queue and discards the responses still in flight by counting them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   redirect_valid/redirect_pc  flush and restart fetch at redirect_pc
//   out_valid/out_ready         head of queue handshake towards decode
//   out_pc/out_inst/out_ex      head entry: PC, instruction, AdEL flag
//   inst_req/inst_addr          read request (held until inst_addr_ok)
//   inst_wr/size/wstrb/wdata    fixed word-read attributes
//   inst_addr_ok                request accepted this cycle
//   inst_data_ok/inst_rdata     in-order read data return
// ============================================================================
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_ex,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [3:0]  inst_wstrb,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = QW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = CW + 2;

    localparam logic [CW-1:0] C_DEPTH     = CW'(QUEUE_DEPTH);
    localparam logic [SW-1:0] C_DEPTH_S   = SW'(QUEUE_DEPTH);
    localparam logic [OW-1:0] C_MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [FW-1:0] C_FL_LAST   = FW'(MAX_OUTSTANDING - 1);

    // Fetch control state
    logic [31:0]   r_fetch_pc;
    logic          r_inst_req;
    logic [31:0]   r_inst_addr;
    logic          r_stale;        // held request predates the last redirect
    logic          r_halt;         // AdEL entry queued, wait for redirect
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;

    // In-flight PC FIFO (one entry per accepted, unreturned read)
    logic [31:0]   r_fl_pc [MAX_OUTSTANDING];
    logic [FW-1:0] r_fl_rd;
    logic [FW-1:0] r_fl_wr;

    // Instruction queue
    logic [31:0]   r_q_pc   [QUEUE_DEPTH];
    logic [31:0]   r_q_inst [QUEUE_DEPTH];
    logic          r_q_ex   [QUEUE_DEPTH];
    logic [QW-1:0] r_q_rd;
    logic [QW-1:0] r_q_wr;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic          w_disc_dec;
    logic          w_data_push;
    logic          w_ex_push;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_out_n;
    logic [OW-1:0] w_disc_n;
    logic [CW-1:0] w_count_n;
    logic [31:0]   w_fetch_pc_n;
    logic [SW-1:0] w_credit;
    logic          w_issue;
    logic [31:0]   w_push_pc;
    logic [31:0]   w_push_inst;
    logic [FW-1:0] w_fl_rd_n;
    logic [FW-1:0] w_fl_wr_n;

    assign w_accept   = r_inst_req && inst_addr_ok;
    assign w_out_n    = r_outstanding + OW'(w_accept) - OW'(inst_data_ok);
    assign w_disc_dec = inst_data_ok && (r_discard != '0);

    // A stale request accepted after its redirect joins the discard count
    // instead of advancing the fetch PC.
    assign w_disc_n = redirect_valid ? w_out_n
                    : r_discard + OW'(w_accept && r_stale) - OW'(w_disc_dec);

    assign w_data_push = inst_data_ok && (r_discard == '0) && !redirect_valid;

    // A misaligned PC produces a single exception entry, but only once the
    // bus is quiet so that it lands behind every older instruction.
    assign w_ex_push = !redirect_valid && (r_fetch_pc[1:0] != 2'b00) && !r_halt
                    && !r_inst_req && (r_outstanding == '0) && (r_discard == '0)
                    && !inst_data_ok && (r_count < C_DEPTH);

    assign w_push    = w_data_push || w_ex_push;
    assign w_pop     = (r_count != '0) && out_ready && !redirect_valid;
    assign w_count_n = redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_fetch_pc_n = r_fetch_pc;
        if (redirect_valid) begin
            w_fetch_pc_n = redirect_pc;
        end else if (w_accept && !r_stale) begin
            w_fetch_pc_n = r_fetch_pc + 32'd4;
        end
    end

    // Every accepted read plus every queued entry (and pending discards, as a
    // conservative margin) must fit in the queue before a new read starts.
    assign w_credit = SW'(w_out_n) + SW'(w_count_n) + SW'(w_disc_n);

    assign w_issue = !redirect_valid && (!r_inst_req || inst_addr_ok) && !r_halt
                  && (w_fetch_pc_n[1:0] == 2'b00) && (w_out_n < C_MAX_OUT)
                  && (w_credit < C_DEPTH_S);

    assign w_push_pc   = w_data_push ? r_fl_pc[r_fl_rd] : r_fetch_pc;
    assign w_push_inst = w_data_push ? inst_rdata : 32'h0;

    assign w_fl_rd_n = (r_fl_rd == C_FL_LAST) ? '0 : r_fl_rd + FW'(1);
    assign w_fl_wr_n = (r_fl_wr == C_FL_LAST) ? '0 : r_fl_wr + FW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inst_req    <= 1'b0;
            r_inst_addr   <= 32'h0;
            r_stale       <= 1'b0;
            r_halt        <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_fl_rd       <= '0;
            r_fl_wr       <= '0;
            r_q_rd        <= '0;
            r_q_wr        <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_n;
            r_outstanding <= w_out_n;
            r_discard     <= w_disc_n;
            r_count       <= w_count_n;

            if (w_issue) begin
                r_inst_req  <= 1'b1;
                r_inst_addr <= w_fetch_pc_n;
            end else if (w_accept) begin
                r_inst_req  <= 1'b0;
            end

            if (redirect_valid) begin
                r_stale <= r_inst_req && !inst_addr_ok;
            end else if (w_accept) begin
                r_stale <= 1'b0;
            end

            if (redirect_valid) begin
                r_halt <= 1'b0;
            end else if (w_ex_push) begin
                r_halt <= 1'b1;
            end

            // The in-flight FIFO is never flushed: discarded responses still
            // pop their PC so the FIFO stays aligned with the bus.
            if (w_accept) begin
                r_fl_wr <= w_fl_wr_n;
            end
            if (inst_data_ok) begin
                r_fl_rd <= w_fl_rd_n;
            end

            if (redirect_valid) begin
                r_q_rd <= '0;
                r_q_wr <= '0;
            end else begin
                if (w_push) begin
                    r_q_wr <= r_q_wr + QW'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + QW'(1);
                end
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_fl_pc[r_fl_wr] <= r_inst_addr;
        end
        if (!reset && w_push) begin
            r_q_pc[r_q_wr]   <= w_push_pc;
            r_q_inst[r_q_wr] <= w_push_inst;
            r_q_ex[r_q_wr]   <= w_ex_push;
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_pc     = r_q_pc[r_q_rd];
    assign out_inst   = r_q_inst[r_q_rd];
    assign out_ex     = r_q_ex[r_q_rd];

    assign inst_req   = r_inst_req;
    assign inst_addr  = r_inst_addr;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'h2;
    assign inst_wstrb = 4'h0;
    assign inst_wdata = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Directed self-checking bench for if_fetch_queue with a small
//            sram-like bus responder (1-cycle data latency, switchable
//            addr_ok / data_ok) and a log of issued and delivered entries.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : none (top-level bench)
// ============================================================================
module tb_if_fetch_queue;

    typedef struct packed {
        logic        ex;
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ex;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    if_fetch_queue #(
        .RESET_PC        (32'hbfc00000),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ex         (out_ex),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_wstrb     (inst_wstrb),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic        aok_en;
    logic        dok_en;
    logic        rdy_en;
    logic        rd_req;
    logic [31:0] rd_pc_v;

    logic [31:0] pend[$];
    logic [31:0] iss[$];
    ent_t        got[$];
    int          max_pend = 0;
    int          held_err = 0;
    logic        prev_held = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        last_dok;
    logic        last_pop;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hdeadbeef;
    endfunction

    function automatic ent_t got_at(input int i);
        if (i < got.size()) return got[i];
        return '0;
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        if (i < iss.size()) return iss[i];
        return 32'h0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge, drive inputs for the next rising edge,
    // model the bus and log what the DUT presents.
    task automatic tick();
        @(negedge clk);
        redirect_valid = rd_req;
        redirect_pc    = rd_pc_v;
        out_ready      = rdy_en;
        inst_addr_ok   = aok_en && inst_req;
        inst_data_ok   = dok_en && (pend.size() > 0);
        inst_rdata     = inst_data_ok ? mem(pend[0]) : 32'h0;
        if (inst_data_ok) pend.delete(0);
        if (inst_addr_ok) begin
            pend.push_back(inst_addr);
            iss.push_back(inst_addr);
        end
        if (pend.size() > max_pend) max_pend = pend.size();
        last_dok = inst_data_ok;
        last_pop = out_valid && out_ready;
        if (out_valid && out_ready) got.push_back({out_ex, out_pc, out_inst});
        if (prev_held && (!inst_req || inst_addr != prev_addr)) held_err++;
        prev_held = inst_req && !inst_addr_ok;
        prev_addr = inst_addr;
        rd_req = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        rd_req  = 1'b1;
        rd_pc_v = pc;
        tick();
        iss.delete();
        got.delete();
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'h0;
        aok_en  = 1'b1;
        dok_en  = 1'b1;
        rdy_en  = 1'b1;
        rd_req  = 1'b0;
        rd_pc_v = 32'h0;

        // Reset state and fixed bus attributes
        repeat (3) tick();
        check_eq("rst_req",   {31'h0, inst_req}, 32'h0);
        check_eq("rst_addr",  inst_addr, 32'h0);
        check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
        check_eq("const_attr", {inst_wr, inst_size, inst_wstrb, 25'h0}, {1'b0, 2'h2, 4'h0, 25'h0});
        check_eq("const_wdata", inst_wdata, 32'h0);
        reset = 1'b0;

        // Streaming from the reset vector, one delivery per cycle
        repeat (12) tick();
        check_eq("stream_count", 32'(got.size()), 32'd10);
        check_eq("stream_pc0",   got_at(0).pc,   32'hbfc00000);
        check_eq("stream_inst0", got_at(0).inst, 32'h616dbeef);
        check_eq("stream_pc1",   got_at(1).pc,   32'hbfc00004);
        check_eq("stream_inst1", got_at(1).inst, 32'h616dbeeb);
        check_eq("stream_pc2",   got_at(2).pc,   32'hbfc00008);
        check_eq("stream_inst2", got_at(2).inst, 32'h616dbee7);
        check_eq("stream_pc3",   got_at(3).pc,   32'hbfc0000c);
        check_eq("stream_inst3", got_at(3).inst, 32'h616dbee3);
        check_eq("stream_ex0",   {31'h0, got_at(0).ex}, 32'h0);

        // Decode stalled: exactly QUEUE_DEPTH reads, then release
        rdy_en = 1'b0;
        do_redirect(32'hbfc00100);
        repeat (20) tick();
        check_eq("stall_issued", 32'(iss.size()), 32'd4);
        check_eq("stall_iss0",   iss_at(0), 32'hbfc00100);
        check_eq("stall_iss3",   iss_at(3), 32'hbfc0010c);
        check_eq("stall_req",    {31'h0, inst_req}, 32'h0);
        check_eq("stall_valid",  {31'h0, out_valid}, 32'h1);
        check_eq("stall_head",   out_pc, 32'hbfc00100);
        check_eq("stall_inst",   out_inst, mem(32'hbfc00100));
        check_eq("stall_popped", 32'(got.size()), 32'd0);
        rdy_en = 1'b1;
        repeat (10) tick();
        check_eq("drain_pc0",   got_at(0).pc, 32'hbfc00100);
        check_eq("drain_pc3",   got_at(3).pc, 32'hbfc0010c);
        check_eq("drain_inst3", got_at(3).inst, mem(32'hbfc0010c));
        check_eq("drain_pc4",   got_at(4).pc, 32'hbfc00110);

        // Two reads outstanding, then redirect: both responses dropped
        dok_en = 1'b0;
        repeat (6) tick();
        check_eq("out2_req",  {31'h0, inst_req}, 32'h0);
        check_eq("out2_pend", 32'(pend.size()), 32'd2);
        do_redirect(32'hbfc00380);
        dok_en = 1'b1;
        repeat (10) tick();
        check_eq("rdr_iss0",  iss_at(0), 32'hbfc00380);
        check_eq("rdr_pc0",   got_at(0).pc, 32'hbfc00380);
        check_eq("rdr_inst0", got_at(0).inst, mem(32'hbfc00380));
        check_eq("rdr_pc1",   got_at(1).pc, 32'hbfc00384);

        // Misaligned redirect: one AdEL entry, no bus traffic, then stall
        do_redirect(32'h80000002);
        repeat (10) tick();
        check_eq("mis_count",  32'(got.size()), 32'd1);
        check_eq("mis_ex",     {31'h0, got_at(0).ex}, 32'h1);
        check_eq("mis_pc",     got_at(0).pc, 32'h80000002);
        check_eq("mis_inst",   got_at(0).inst, 32'h0);
        check_eq("mis_issued", 32'(iss.size()), 32'd0);
        check_eq("mis_req",    {31'h0, inst_req}, 32'h0);
        check_eq("mis_valid",  {31'h0, out_valid}, 32'h0);

        // Redirect while a request is held unaccepted
        aok_en = 1'b0;
        do_redirect(32'hbfc00400);
        repeat (3) tick();
        check_eq("held_req",  {31'h0, inst_req}, 32'h1);
        check_eq("held_addr", inst_addr, 32'hbfc00400);
        do_redirect(32'hbfc00500);
        repeat (2) tick();
        check_eq("stale_req",  {31'h0, inst_req}, 32'h1);
        check_eq("stale_addr", inst_addr, 32'hbfc00400);
        aok_en = 1'b1;
        repeat (12) tick();
        check_eq("stale_iss0", iss_at(0), 32'hbfc00400);
        check_eq("stale_iss1", iss_at(1), 32'hbfc00500);
        check_eq("stale_pc0",  got_at(0).pc, 32'hbfc00500);
        check_eq("stale_inst", got_at(0).inst, mem(32'hbfc00500));

        // Redirect coinciding with a data return and a decode pop
        repeat (3) tick();
        do_redirect(32'hbfc00600);
        check_eq("coinc_dok_pop", {30'h0, last_dok, last_pop}, 32'h3);
        @(posedge clk);
        #1;
        check_eq("coinc_flush", {31'h0, out_valid}, 32'h0);
        repeat (10) tick();
        check_eq("coinc_pc0",   got_at(0).pc, 32'hbfc00600);
        check_eq("coinc_inst0", got_at(0).inst, mem(32'hbfc00600));
        check_eq("coinc_pc1",   got_at(1).pc, 32'hbfc00604);
        check_eq("coinc_pc3",   got_at(3).pc, 32'hbfc0060c);

        // Bus protocol properties over the whole run
        check_eq("held_stable", 32'(held_err), 32'd0);
        check_eq("max_outstanding_ok", {31'h0, (max_pend <= 2)}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
